shift_add_multiplier_param: RTL and testbench
=============================================

Name: shift_add_multiplier_param

Overview:
- Parametrised sequential unsigned multiplier using the shift-add algorithm; successor to the fixed 4-bit combinational adder stage.
- Computes A*B over WIDTH iterations using one internal (WIDTH+1)-bit adder, so the carry out is kept in the same way as the 4-bit/5-bit sum stage.
- Uses a Start/Ready/Done handshake.
- Sits between the operand registers and the result bus of the multiplier datapath.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..32); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- Clock  input  1  rising-edge clock, single domain.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only while Ready=1.
- OperandoA  input  WIDTH  multiplicand; latched on accepted Start.
- OperandoB  input  WIDTH  multiplier; latched on accepted Start.
- Ready  output  1  high in IDLE; block accepts Start.
- Busy  output  1  high while iterating (CALC).
- Done  output  1  one-cycle pulse; Produto valid and new.
- Produto  output  2*WIDTH  registered result; holds until the next completion.

Behaviour:
- Reset is synchronous and active-high; one clock.
  - On Reset=1 at a rising edge, regardless of state: state=IDLE, Ready=1, Busy=0, Done=0, Produto=0, and all internal registers cleared.
  - Reset mid-operation aborts the operation; no Done is produced.
- FSM states: IDLE, CALC, FIN.
  - IDLE: Ready=1. On Start=1 at edge k: M<=OperandoA, Q<=OperandoB, P<=0 (WIDTH+1 bits incl. carry), cnt<=WIDTH; go to CALC. Start=0 stays in IDLE.
  - CALC: Busy=1, Ready=0.
    - Per edge: sum = {1'b0,P[WIDTH-1:0]} + (Q[0] ? {1'b0,M} : 0), computed in WIDTH+1 bits with no truncation.
    - Then {P,Q} <= {sum,Q} >> 1, with the carry shifted into the MSB.
    - cnt decrements each edge. When cnt reaches 1 at an edge, that edge performs the last iteration and moves to FIN.
  - FIN: Done=1 for exactly this cycle; Produto = {P[WIDTH-1:0],Q}, registered on the edge entering FIN. Next edge returns to IDLE.
- Latency:
  - Start accepted at edge k; iterations on edges k+1..k+WIDTH.
  - Done=1 and Produto valid in the cycle after edge k+WIDTH.
  - Ready=1 again after edge k+WIDTH+1.
  - Throughput: one product per WIDTH+2 cycles.
- Start handling:
  - Start is ignored while Ready=0, i.e. in CALC or FIN; it is not queued.
  - Operand changes after acceptance have no effect.
  - Start held high continuously gives back-to-back operations, each accepted in IDLE.
- Produto changes only on entry to FIN or on Reset. It is stable in all other cycles, including during the next operation.
- Arithmetic:
  - Unsigned only.
  - The maximum result (2^WIDTH-1)^2 fits in 2*WIDTH bits; no overflow is possible.
  - The internal carry bit must never be dropped.
- Zero operands are not treated specially (no early termination); latency is fixed at WIDTH+1 cycles to Done.
- Busy and Ready are never both 1. Done implies Busy=0 and Ready=0.

Test Plan:
- WIDTH=4, A=3, B=5, Start pulse at edge k -> Busy high for 4 cycles, Done pulse in the cycle after edge k+4, Produto=15, Ready=1 after edge k+5.
- WIDTH=4, A=15, B=15 -> Produto=225 (8'hE1). Checks carry propagation through the 5-bit adder path. Also A=0,B=9 -> Produto=0 with the same latency.
- WIDTH=8, A=255, B=255 -> Produto=65025 (16'hFE01) after 8 iterations. Also A=200, B=3 -> 600.
- WIDTH=4, A=7, B=8 accepted. Start with A=9, B=6 pulsed during CALC and again in FIN -> both ignored; single Done with Produto=56. Produto unchanged until the next accepted Start completes.
- WIDTH=4, A=15, B=1 accepted; Reset asserted at iteration 2 -> next cycle Ready=1, Busy=0, Done=0, Produto=0; no Done pulse follows. A new Start with A=9, B=6 -> Produto=54.
- Start held high for 3 operations (A=3/B=5, A=15/B=1, A=7/B=8), operands changed only while Ready=1 -> Done pulses spaced 6 cycles apart; Produto=15, 15, 56 in turn.

Source files
------------

// File: rtl/shift_add_multiplier_param.sv
// Sequential unsigned shift-add multiplier with a Start/Ready/Done handshake.
// One (WIDTH+1)-bit adder per iteration; its carry is shifted back into P so no bit is lost.
module shift_add_multiplier_param #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   OperandoA,
  input  logic [WIDTH-1:0]   OperandoB,
  output logic               Ready,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Produto
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH:0]     p_q, p_d;
  logic [WIDTH:0]     sum;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    // P's top bit is always 0 after each shift, so p_q equals {1'b0, P[WIDTH-1:0]}.
    sum     = p_q + (q_q[0] ? {1'b0, m_q} : '0);

    case (state_q)
      IDLE: begin
        if (Start) begin
          m_d     = OperandoA;
          q_d     = OperandoB;
          p_d     = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = CALC;
        end
      end
      CALC: begin
        p_d   = {1'b0, sum[WIDTH:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          prod_d  = {p_d[WIDTH-1:0], q_d};
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Ready   = (state_q == IDLE);
  assign Busy    = (state_q == CALC);
  assign Done    = (state_q == FIN);
  assign Produto = prod_q;

endmodule

// File: tb/tb_shift_add_multiplier_param.sv
// Self-checking bench for shift_add_multiplier_param: WIDTH=4 and WIDTH=8 instances,
// table-driven vectors plus hand sequences, products checked through a scoreboard queue.
module tb_shift_add_multiplier_param;

  typedef struct {
    logic        wide;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] expected;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        ready4, busy4, done4;
  logic        ready8, busy8, done8;
  logic [7:0]  produto4;
  logic [15:0] produto8;

  int          total = 0;
  int          bad = 0;
  int          cycle = 0;
  logic        resetAtEdge = 1'b1;
  logic [7:0]  prevProd4;
  logic [15:0] prevProd8;
  logic [7:0]  sb4[$];
  logic [15:0] sb8[$];
  int          doneCycles4[$];

  shift_add_multiplier_param #(.WIDTH(4)) dut4 (
    .Clock(clock), .Reset(reset), .Start(start4),
    .OperandoA(a4), .OperandoB(b4),
    .Ready(ready4), .Busy(busy4), .Done(done4), .Produto(produto4)
  );

  shift_add_multiplier_param #(.WIDTH(8)) dut8 (
    .Clock(clock), .Reset(reset), .Start(start8),
    .OperandoA(a8), .OperandoB(b8),
    .Ready(ready8), .Busy(busy8), .Done(done8), .Produto(produto8)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Cycle counter and a record of whether reset was applied at the last edge.
  always @(posedge clock) begin
    cycle       <= cycle + 1;
    resetAtEdge <= reset;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard side: every Done pops one expected product; in between, Produto must hold.
  always @(negedge clock) begin
    checkOutput("excl4", 32'(busy4 & ready4), 0);
    checkOutput("excl8", 32'(busy8 & ready8), 0);
    checkOutput("doneIdle4", 32'(done4 & (busy4 | ready4)), 0);
    checkOutput("doneIdle8", 32'(done8 & (busy8 | ready8)), 0);
    if (done4) begin
      doneCycles4.push_back(cycle);
      if (sb4.size() == 0) checkOutput("unexpectedDone4", 32'(done4), 0);
      else checkOutput("prod4", 32'(produto4), 32'(sb4.pop_front()));
    end else if (!resetAtEdge) begin
      checkOutput("hold4", 32'(produto4), 32'(prevProd4));
    end
    if (done8) begin
      if (sb8.size() == 0) checkOutput("unexpectedDone8", 32'(done8), 0);
      else checkOutput("prod8", 32'(produto8), 32'(sb8.pop_front()));
    end else if (!resetAtEdge) begin
      checkOutput("hold8", 32'(produto8), 32'(prevProd8));
    end
    prevProd4 = produto4;
    prevProd8 = produto8;
  end

  // Drives one operation from a Ready cycle and checks the Busy/Done/Ready timeline.
  task automatic applyStimulus(input logic wide, input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] expected);
    int n;
    int iters;
    n = 0;
    iters = wide ? 8 : 4;
    while (!(wide ? ready8 : ready4) && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("readyBeforeStart", 32'(wide ? ready8 : ready4), 1);
    if (wide) begin
      a8 = a; b8 = b; start8 = 1'b1;
      sb8.push_back(expected);
    end else begin
      a4 = a[3:0]; b4 = b[3:0]; start4 = 1'b1;
      sb4.push_back(expected[7:0]);
    end
    @(posedge clock);
    #1;
    start4 = 1'b0;
    start8 = 1'b0;
    for (int c = 0; c < iters; c++) begin
      @(negedge clock);
      checkOutput("busyIter", 32'(wide ? busy8 : busy4), 1);
      checkOutput("doneIter", 32'(wide ? done8 : done4), 0);
    end
    @(negedge clock);
    checkOutput("donePulse", 32'(wide ? done8 : done4), 1);
    @(negedge clock);
    checkOutput("readyAfter", 32'(wide ? ready8 : ready4), 1);
    checkOutput("doneAfter", 32'(wide ? done8 : done4), 0);
  endtask

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, vector table, then the multi-cycle corner cases.
  initial begin
    vec_t vecs[6];
    int   n;
    int   base;
    int   ha[3];
    int   hb[3];
    int   he[3];

    reset = 1'b1; start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("rstReady4", 32'(ready4), 1);
    checkOutput("rstBusy4", 32'(busy4), 0);
    checkOutput("rstDone4", 32'(done4), 0);
    checkOutput("rstProd4", 32'(produto4), 0);
    checkOutput("rstReady8", 32'(ready8), 1);
    checkOutput("rstProd8", 32'(produto8), 0);

    vecs[0] = '{1'b0, 8'd3,   8'd5,   16'd15};
    vecs[1] = '{1'b0, 8'd15,  8'd15,  16'd225};
    vecs[2] = '{1'b0, 8'd0,   8'd9,   16'd0};
    vecs[3] = '{1'b0, 8'd10,  8'd11,  16'd110};
    vecs[4] = '{1'b1, 8'd255, 8'd255, 16'd65025};
    vecs[5] = '{1'b1, 8'd200, 8'd3,   16'd600};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].wide, vecs[i].a, vecs[i].b, vecs[i].expected);
    end

    // Start pulses during CALC and FIN must be ignored; operand changes have no effect.
    a4 = 4'd7; b4 = 4'd8; start4 = 1'b1;
    sb4.push_back(8'd56);
    @(posedge clock);
    #1 start4 = 1'b0; a4 = 4'd9; b4 = 4'd6;
    @(negedge clock);
    start4 = 1'b1;
    @(posedge clock);
    #1 start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput("ignDone", 32'(done4), 1);
    start4 = 1'b1;
    @(posedge clock);
    #1 start4 = 1'b0;
    @(negedge clock);
    checkOutput("ignReady", 32'(ready4), 1);
    checkOutput("ignBusy", 32'(busy4), 0);
    @(negedge clock);
    checkOutput("ignBusy2", 32'(busy4), 0);
    checkOutput("ignProd", 32'(produto4), 56);

    // Reset during the second iteration aborts without a Done pulse.
    a4 = 4'd15; b4 = 4'd1; start4 = 1'b1;
    @(posedge clock);
    #1 start4 = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("abortReady", 32'(ready4), 1);
    checkOutput("abortBusy", 32'(busy4), 0);
    checkOutput("abortDone", 32'(done4), 0);
    checkOutput("abortProd", 32'(produto4), 0);
    repeat (8) begin
      @(negedge clock);
      checkOutput("abortNoDone", 32'(done4), 0);
    end
    applyStimulus(1'b0, 8'd9, 8'd6, 16'd54);

    // Start held high: back-to-back operations, operands changed only while Ready=1.
    ha = '{3, 15, 7};
    hb = '{5, 1, 8};
    he = '{15, 15, 56};
    base = doneCycles4.size();
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!ready4 && n < 20) begin
        @(negedge clock);
        n++;
      end
      checkOutput("heldReady", 32'(ready4), 1);
      a4 = 4'(ha[i]); b4 = 4'(hb[i]); start4 = 1'b1;
      sb4.push_back(8'(he[i]));
      @(posedge clock);
      #1;
      if (i == 2) start4 = 1'b0;
      @(negedge clock);
    end
    n = 0;
    while (sb4.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    checkOutput("heldCount", 32'(doneCycles4.size() - base), 3);
    if (doneCycles4.size() >= base + 3) begin
      checkOutput("heldSpacing1", 32'(doneCycles4[base + 1] - doneCycles4[base]), 6);
      checkOutput("heldSpacing2", 32'(doneCycles4[base + 2] - doneCycles4[base + 1]), 6);
    end

    checkOutput("sb4Empty", 32'(sb4.size()), 0);
    checkOutput("sb8Empty", 32'(sb8.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
